// File: rtl/priority_encoder_pkg.sv
// priority_encoder_pkg: widths and types shared by the 8-to-3 priority encoder
package priority_encoder_pkg;
  localparam int IN_W = 8;
  localparam int OUT_W = 3;
  typedef logic [IN_W-1:0] req_t;
  typedef logic [OUT_W-1:0] idx_t;
endpackage

// File: rtl/penc_comb_8to3.sv
// penc_comb_8to3: combinational 8-to-3 priority logic, bit 7 wins
module penc_comb_8to3
  import priority_encoder_pkg::*;
(
  input  req_t in,
  output idx_t idx,
  output logic any
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < IN_W; i++) idx = in[i] ? idx_t'(i) : idx;
    any = |in;
  end
endmodule

// File: rtl/priority_encoder_8to3.sv
// priority_encoder_8to3: registered 8-to-3 priority encoder, onehot port under PRIORITY_ENCODER_ONEHOT_EN
module priority_encoder_8to3
  import priority_encoder_pkg::*;
#(
  parameter idx_t ZERO_CODE = 3'b000
) (
  input  logic clk,
  input  logic rst,
  input  req_t in,
  output idx_t out,
  output logic valid
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  ,
  output req_t onehot
`endif
);
  idx_t idx;
  logic any;
  penc_comb_8to3 u_comb (.in(in), .idx(idx), .any(any));
  always_ff @(posedge clk) begin
    out   <= rst ? '0 : any ? idx : ZERO_CODE;
    valid <= !rst && any;
  end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  always_ff @(posedge clk) onehot <= (rst || !any) ? '0 : req_t'(1) << idx;
`endif
endmodule

// File: tb/tb_priority_encoder_8to3.sv
// tb_priority_encoder_8to3: scoreboard bench for the registered priority encoder
module tb_priority_encoder_8to3;
  localparam logic [2:0] ZC = 3'b101;
  typedef struct packed {
    logic [2:0] o;
    logic       v;
    logic [7:0] oh;
  } exp_t;
  logic clk, rst;
  logic [7:0] in;
  logic [2:0] out;
  logic valid;
  logic [7:0] onehot;
  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  priority_encoder_8to3 #(.ZERO_CODE(ZC)) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .out(out),
    .valid(valid)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    ,
    .onehot(onehot)
`endif
  );
`ifndef PRIORITY_ENCODER_ONEHOT_EN
  assign onehot = 8'h00;
`endif
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [2:0] ref_idx(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic [7:0] v);
    exp_t e;
    @(negedge clk);
    rst = r;
    in = v;
    e.v = !r && (v != 8'h00);
    e.o = r ? 3'd0 : (v != 8'h00) ? ref_idx(v) : ZC;
    e.oh = e.v ? 8'd1 << e.o : 8'd0;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = q.pop_front();
      check($sformatf("out rst=%0b in=%h", r, v), 32'(out), 32'(e.o));
      check($sformatf("valid rst=%0b in=%h", r, v), 32'(valid), 32'(e.v));
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      check($sformatf("onehot rst=%0b in=%h", r, v), 32'(onehot), 32'(e.oh));
`endif
    end
  endtask
  initial begin
    logic [7:0] sweep [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    rst = 1;
    in = 8'h00;
    step(1, 8'hA5);
    step(1, 8'hFF);
    foreach (sweep[i]) step(0, sweep[i]);
    step(0, 8'h00);
    step(0, 8'b0010_1001);
    step(0, 8'h80);
    step(1, 8'h80);
    step(0, 8'h80);
    step(1, 8'h00);
    step(0, 8'h01);
    for (int v = 0; v < 256; v++) step(0, 8'(v));
    for (int k = 0; k < 40; k++) step($urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
